dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the slave end of the datapath's load/store interface.
- Accepts one load or store request through a valid/ready handshake.
- Inserts a configurable number of wait states, performs the access on a doubleword-addressed array, and returns a response through a valid/ready handshake.
- Replaces the single-cycle data memory when the core moves to a stalling, handshaked memory port.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the handshaked data-memory responder.
//   DWORD_W    - stored word width (bits)
//   BYTE_OFS_W - byte-offset bits below the doubleword index
//   WAIT_CNT_W - width of the wait-state down-counter (LATENCY 0..15)
//   dmem_state_e - responder FSM encoding
package dmem_pkg;

  localparam int DWORD_W    = 64;
  localparam int BYTE_OFS_W = 3;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_CLEAR = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port doubleword store, synchronous write, registered read.
//   clk, rst  - clock, async active-low reset (read register only)
//   i_we      - write i_wdata to i_addr on the rising edge
//   i_re      - capture the word at i_addr into o_rdata on the rising edge
//   i_addr    - word index
//   i_wdata   - write data
//   o_rdata   - registered read data, held between read enables
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [AW-1:0]      i_addr,
  input  logic [DWORD_W-1:0] i_wdata,
  output logic [DWORD_W-1:0] o_rdata
);

  logic [DWORD_W-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Read-before-write on a shared address; callers mask store responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave with valid/ready request and
// response channels and LATENCY wait states between accept and response.
//   clk, rst           - clock, async active-low reset
//   req_valid/ready    - request handshake (ready only in IDLE)
//   req_write          - 1 = store, 0 = load
//   req_addr/req_wdata - byte address, store data
//   rsp_valid/ready    - response handshake (valid only in RESP)
//   rsp_rdata/rsp_err  - load data (0 for stores/errors), misaligned/out-of-range
// Optional macro DMEM_INIT_CLEAR_EN: zero the array after reset via CLEAR sweep.
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1 once out of reset)
// WAIT  | counting wait states down to zero
// RESP  | response presented, held until rsp_ready
// CLEAR | post-reset zeroing sweep (DMEM_INIT_CLEAR_EN only)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [DWORD_W-1:0] req_addr,
  input  logic [DWORD_W-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DWORD_W-1:0] rsp_rdata,
  output logic               rsp_err
);

  localparam int IDX_W = DWORD_W - BYTE_OFS_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]      DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (LATENCY > 0) ? WAIT_CNT_W'(LATENCY - 1) : WAIT_CNT_W'(0);
`ifdef DMEM_INIT_CLEAR_EN
  localparam dmem_state_e RST_STATE = ST_CLEAR;
`else
  localparam dmem_state_e RST_STATE = ST_IDLE;
`endif

  dmem_state_e             r_state, w_next;
  logic                    r_ready_en;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt;
  logic                    r_write;
  logic [DWORD_W-1:0]      r_addr, r_wdata;
  logic                    r_rsp_err, r_rsp_load;

  logic                    w_accept, w_enter_resp, w_err;
  logic                    w_acc_write;
  logic [DWORD_W-1:0]      w_acc_addr, w_acc_wdata;
  logic [IDX_W-1:0]        w_acc_idx;
  logic                    w_clr_we, w_clr_last;
  logic [AW-1:0]           w_clr_idx;
  logic                    w_arr_we;
  logic [AW-1:0]           w_arr_addr;
  logic [DWORD_W-1:0]      w_arr_wdata, w_arr_rdata;

  // r_ready_en keeps req_ready low while reset is held even though the
  // state register already reads IDLE.
  assign req_ready = r_ready_en && (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_load ? w_arr_rdata : '0;
  assign w_accept  = req_ready && req_valid;

  // With LATENCY = 0 the access happens on the accept edge itself, so the
  // live request fields are used in IDLE and the latched copy otherwise.
  assign w_acc_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_acc_idx   = w_acc_addr[DWORD_W-1:BYTE_OFS_W];
  assign w_err       = (w_acc_addr[BYTE_OFS_W-1:0] != '0) || (w_acc_idx >= DEPTH_IDX);

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      ST_CLEAR: if (w_clr_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RST_STATE;
      r_ready_en <= 1'b0;
      r_wait_cnt <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_enter_resp) begin
        r_rsp_err  <= w_err;
        r_rsp_load <= !w_err && !w_acc_write;
      end
    end
  end

`ifdef DMEM_INIT_CLEAR_EN
  logic [AW-1:0] r_clr_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_clr_idx <= '0;
    else if (r_state == ST_CLEAR)   r_clr_idx <= r_clr_idx + 1'b1;
  end

  assign w_clr_we   = (r_state == ST_CLEAR);
  assign w_clr_last = (r_clr_idx == AW'(DEPTH - 1));
  assign w_clr_idx  = r_clr_idx;
`else
  assign w_clr_we   = 1'b0;
  assign w_clr_last = 1'b1;
  assign w_clr_idx  = '0;
`endif

  assign w_arr_we    = w_clr_we || (w_enter_resp && w_acc_write && !w_err);
  assign w_arr_addr  = w_clr_we ? w_clr_idx : w_acc_idx[AW-1:0];
  assign w_arr_wdata = w_clr_we ? '0 : w_acc_wdata;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_arr_we),
    .i_re    (w_enter_resp),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Instance u_dut uses
// LATENCY=2, u_dut_z uses LATENCY=0. Honours DMEM_INIT_CLEAR_EN when defined.
module tb_dmem_responder;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic        req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
  logic [63:0] req_addr_z, req_wdata_z, rsp_rdata_z;

  int n_checks = 0;
  int n_err    = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: actual timeout required handshake", nm);
  endtask

  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int lat);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready) timeout_fail("req_ready_wait");
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_req_z(input logic w, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output int lat);
    int guard = 0;
    @(negedge clk);
    req_valid_z = 1'b1; req_write_z = w; req_addr_z = a; req_wdata_z = d;
    while (!req_ready_z && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready_z) timeout_fail("req_ready_z_wait");
    @(posedge clk); #1;
    req_valid_z = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid_z && lat < 50);
    rd = rsp_rdata_z; er = rsp_err_z;
    rsp_ready_z = 1'b1;
    @(posedge clk); #1;
    rsp_ready_z = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    logic [63:0] rd, cap_rd, exp_after;
    logic        er, cap_err, stable, data_ok;
    int          lat, k, n_acc, n_val, guard;

    vecs[0]  = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[2]  = '{1'b1, 64'h08,  64'h01234567_89ABCDEF, 64'h0, 1'b0};
    vecs[3]  = '{1'b1, 64'h00,  64'hFEDCBA98_76543210, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 64'h0C,  64'h0, 64'h0, 1'b1};
    vecs[5]  = '{1'b0, 64'h200, 64'h0, 64'h0, 1'b1};
    vecs[6]  = '{1'b1, 64'h0C,  64'h11111111_11111111, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 64'h200, 64'h22222222_22222222, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 64'h08,  64'h0, 64'h01234567_89ABCDEF, 1'b0};
    vecs[9]  = '{1'b0, 64'h00,  64'h0, 64'hFEDCBA98_76543210, 1'b0};
    vecs[10] = '{1'b1, 64'h1F8, 64'hA5A5A5A5_A5A5A5A5, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 64'h1F8, 64'h0, 64'hA5A5A5A5_A5A5A5A5, 1'b0};
    vecs[12] = '{1'b0, 64'h80000000_00000010, 64'h0, 64'h0, 1'b1};
    vecs[13] = '{1'b1, 64'h80000000_00000010, 64'h33333333_33333333, 64'h0, 1'b1};
    vecs[14] = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[15] = '{1'b1, 64'h10,  64'h0, 64'h0, 1'b0};
    vecs[16] = '{1'b0, 64'h10,  64'h0, 64'h0, 1'b0};

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; rsp_ready_z = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    chk("rst_rsp_err",   64'(rsp_err), 64'h0);
    rst = 1'b1;

`ifdef DMEM_INIT_CLEAR_EN
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 200);
    chk("clear_ready_cycles", 64'(k), 64'd64);
    do_req(1'b0, 64'h1F8, 64'h0, rd, er, lat);
    chk("clear_load_1f8", rd, 64'h0);
    chk("clear_load_1f8_err", 64'(er), 64'h0);
`else
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'h1);
`endif

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end

    // Response held with rsp_ready low while a second request is pending.
    do_req(1'b1, 64'h18, 64'h5A5A5A5A_0F0F0F0F, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h18; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    chk("hold_latency", 64'(lat), 64'd3);
    cap_rd = rsp_rdata; cap_err = rsp_err;
    chk("hold_rdata", cap_rd, 64'h5A5A5A5A_0F0F0F0F);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h77777777_77777777;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== cap_rd || rsp_err !== cap_err || req_ready) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'h1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_req_ready", 64'(req_ready), 64'h1);
    chk("after_hs_rsp_valid", 64'(rsp_valid), 64'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    chk("second_req_latency", 64'(lat), 64'd3);
    chk("second_req_err", 64'(rsp_err), 64'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_req(1'b0, 64'h20, 64'h0, rd, er, lat);
    chk("second_req_written", rd, 64'h77777777_77777777);

    // LATENCY = 0 instance.
    do_req_z(1'b1, 64'h30, 64'h00000000_00001234, rd, er, lat);
    chk("z_store_latency", 64'(lat), 64'd1);
    chk("z_store_rdata", rd, 64'h0);
    do_req_z(1'b0, 64'h30, 64'h0, rd, er, lat);
    chk("z_load_latency", 64'(lat), 64'd1);
    chk("z_load_rdata", rd, 64'h00000000_00001234);
    do_req_z(1'b0, 64'h31, 64'h0, rd, er, lat);
    chk("z_misaligned_err", 64'(er), 64'h1);
    chk("z_misaligned_rdata", rd, 64'h0);

    @(negedge clk);
    req_valid_z = 1'b1; req_write_z = 1'b0; req_addr_z = 64'h30; rsp_ready_z = 1'b1;
    n_acc = 0; n_val = 0; data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready_z) n_acc++;
      if (rsp_valid_z) begin
        n_val++;
        if (rsp_rdata_z !== 64'h1234 || rsp_err_z !== 1'b0) data_ok = 1'b0;
      end
      @(negedge clk);
    end
    req_valid_z = 1'b0; rsp_ready_z = 1'b0;
    chk("z_b2b_accepts", 64'(n_acc), 64'd5);
    chk("z_b2b_responses", 64'(n_val), 64'd5);
    chk("z_b2b_data", 64'(data_ok), 64'h1);

    // Reset during WAIT of a store abandons it.
    do_req(1'b0, 64'h08, 64'h0, rd, er, lat);
    chk("pre_rst_load", rd, 64'h01234567_89ABCDEF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h08; req_wdata = 64'hBADBADBA_DBADBAD0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_rdata_before_rst", rsp_rdata, 64'h01234567_89ABCDEF);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midrst_rsp_rdata", rsp_rdata, 64'h0);
    chk("midrst_rsp_err",   64'(rsp_err), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 200);
`ifdef DMEM_INIT_CLEAR_EN
    exp_after = 64'h0;
`else
    exp_after = 64'h01234567_89ABCDEF;
`endif
    do_req(1'b0, 64'h08, 64'h0, rd, er, lat);
    chk("abandoned_store", rd, exp_after);
    chk("abandoned_store_err", 64'(er), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
